// File: rtl/vrvv_pkg.sv
// Shared vector-register-group definitions.
//   - vlmul code constants (integer and fractional LMUL settings)
//   - grp_len(vlmul): number of registers in a group, 4 bits (1, 2, 4 or 8)
package vrvv_pkg;

  localparam logic [2:0] VLMUL_M1   = 3'd0;
  localparam logic [2:0] VLMUL_M2   = 3'd1;
  localparam logic [2:0] VLMUL_M4   = 3'd2;
  localparam logic [2:0] VLMUL_M8   = 3'd3;
  localparam logic [2:0] VLMUL_RSVD = 3'd4;
  localparam logic [2:0] VLMUL_MF8  = 3'd5;
  localparam logic [2:0] VLMUL_MF4  = 3'd6;
  localparam logic [2:0] VLMUL_MF2  = 3'd7;

  // Fractional (and reserved) settings still occupy one whole register.
  function automatic logic [3:0] grp_len(input logic [2:0] vlmul);
    logic [3:0] len;
    case (vlmul)
      VLMUL_M1:   len = 4'd1;
      VLMUL_M2:   len = 4'd2;
      VLMUL_M4:   len = 4'd4;
      VLMUL_M8:   len = 4'd8;
      VLMUL_RSVD,
      VLMUL_MF8,
      VLMUL_MF4,
      VLMUL_MF2:  len = 4'd1;
      default:    len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/vreg_group_issue_if.sv
// Bundle between the decoder / address generator side and vreg_group_issue.
//   flush, in_valid, in_vlmul, in_addr : request side, driven by master
//   in_ready                           : queue can accept, driven by slave
//   agu_en, agu_vlmul, agu_addr        : issue to the generator, driven by slave
//   agu_idle                           : generator idle flag, driven by master
//   grp_valid, grp_last, empty         : status, driven by slave
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready does not depend on in_valid. agu_en is a
// single-cycle strobe with no back-pressure; agu_vlmul/agu_addr are only
// meaningful in cycles where agu_en is 1.
interface vreg_group_issue_if #(
  parameter int ADDR_WIDTH = 5
);
  import vrvv_pkg::*;

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_vlmul;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  agu_en;
  logic [2:0]            agu_vlmul;
  logic [ADDR_WIDTH-1:0] agu_addr;
  logic                  agu_idle;
  logic                  grp_valid;
  logic                  grp_last;
  logic                  empty;

  modport master (
    output flush, in_valid, in_vlmul, in_addr, agu_idle,
    input  in_ready, agu_en, agu_vlmul, agu_addr, grp_valid, grp_last, empty
  );

  modport slave (
    input  flush, in_valid, in_vlmul, in_addr, agu_idle,
    output in_ready, agu_en, agu_vlmul, agu_addr, grp_valid, grp_last, empty
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping read/write pointers and occupancy count.
//   clk, rst   : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop head entry (ignored when empty)
//   i_flush    : clear pointers and count; wins over push/pop
//   o_data     : head entry (combinational, stale when empty)
//   o_full, o_empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/vreg_group_issue.sv
// Issue buffer in front of the vector register-group address generator.
// Queues {vlmul, base} requests, strobes agu_en when the generator can take a
// new group (back-to-back on the last address cycle of the previous group),
// and tracks group length to mark valid / last generator output cycles.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : vreg_group_issue_if.slave (request, issue and status signals)
module vreg_group_issue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  vreg_group_issue_if.slave   bus
);
  import vrvv_pkg::*;

  localparam int EW = 3 + ADDR_WIDTH;

  logic [EW-1:0]         w_head;
  logic [2:0]            w_head_vlmul;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_in_ready;
  logic                  w_push;
  logic                  w_issue_ok;
  logic                  w_agu_en;

  // Remaining generator output cycles of the group in flight.
  logic [3:0]            r_cnt;

  assign w_head_vlmul = w_head[EW-1:ADDR_WIDTH];
  assign w_head_addr  = w_head[ADDR_WIDTH-1:0];

  assign w_in_ready = !w_full && !bus.flush;
  assign w_push     = bus.in_valid && w_in_ready;

  // cnt == 1 is the last address cycle: issuing there chains with no bubble.
  // cnt == 0 with agu_idle low means the generator is still leaving BUSY.
  assign w_issue_ok = (r_cnt == 4'd1) || ((r_cnt == 4'd0) && bus.agu_idle);
  assign w_agu_en   = !w_empty && w_issue_ok && !bus.flush;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_agu_en),
    .i_flush (bus.flush),
    .i_data  ({bus.in_vlmul, bus.in_addr}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Flush leaves cnt alone so an in-flight group still finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_agu_en) begin
      r_cnt <= grp_len(w_head_vlmul);
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.agu_en    = w_agu_en;
  assign bus.agu_vlmul = w_head_vlmul;
  assign bus.agu_addr  = w_head_addr;
  assign bus.grp_valid = (r_cnt != 4'd0);
  assign bus.grp_last  = (r_cnt == 4'd1);
  assign bus.empty     = w_empty;

endmodule

// File: tb/tb_vreg_group_issue.sv
// Bench for vreg_group_issue: directed table, hand-written corner sequences
// and randomized traffic against a schedule-based reference model.
module tb_vreg_group_issue;

  localparam int AW = 5;
  localparam int DP = 4;

  logic clk;
  logic rst;

  vreg_group_issue_if #(.ADDR_WIDTH(AW)) bus ();

  vreg_group_issue #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A group issued in cycle t with length L is visible in cycles t+1..t+L.
  // The model keeps only the last issue cycle and its length.
  int cyc;
  int last_iss;
  int last_len;
  logic [7:0] exp_q[$];   // {vlmul, addr}

  logic s_ready, s_empty, s_en, s_gv, s_gl;

  function automatic int len_of(input logic [2:0] vl);
    return (vl < 3'd4) ? (1 << vl) : 1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_iss = -1000;
    last_len = 0;
  endtask

  // Called one time unit after a rising edge; applies inputs, checks
  // mid-cycle, advances the model and returns one time unit after the next edge.
  task automatic step(input logic f, input logic v, input logic [2:0] vl,
                      input logic [AW-1:0] a, input logic idle);
    logic e_empty, e_ready, e_ok, e_en, e_gv, e_gl;
    int   gend;
    bus.flush    = f;
    bus.in_valid = v;
    bus.in_vlmul = vl;
    bus.in_addr  = a;
    bus.agu_idle = idle;
    #4;
    gend    = last_iss + last_len;
    e_empty = (exp_q.size() == 0);
    e_ready = (exp_q.size() < DP) && !f;
    e_ok    = (cyc == gend && last_len != 0) || (cyc > gend && idle);
    e_en    = !e_empty && e_ok && !f;
    e_gv    = (cyc > last_iss) && (cyc <= gend);
    e_gl    = (last_len != 0) && (cyc == gend);
    s_ready = bus.in_ready;
    s_empty = bus.empty;
    s_en    = bus.agu_en;
    s_gv    = bus.grp_valid;
    s_gl    = bus.grp_last;
    check("in_ready",  32'(s_ready), 32'(e_ready));
    check("empty",     32'(s_empty), 32'(e_empty));
    check("agu_en",    32'(s_en),    32'(e_en));
    check("grp_valid", 32'(s_gv),    32'(e_gv));
    check("grp_last",  32'(s_gl),    32'(e_gl));
    if (!e_empty) begin
      check("agu_addr",  32'(bus.agu_addr),  32'(exp_q[0][4:0]));
      check("agu_vlmul", 32'(bus.agu_vlmul), 32'(exp_q[0][7:5]));
    end
    if (e_en) begin
      last_iss = cyc;
      last_len = len_of(exp_q[0][7:5]);
      void'(exp_q.pop_front());
    end
    if (f) exp_q.delete();
    else if (v && e_ready) exp_q.push_back({vl, a});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vlmul = 3'd0;
    bus.in_addr  = '0;
    bus.agu_idle = 1'b1;
  endtask

  // Assert reset one time unit after an edge, hold across two edges, release
  // away from the edge; outputs are checked while reset is held.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_empty",     32'(bus.empty),     32'd1);
    check("rst_agu_en",    32'(bus.agu_en),    32'd0);
    check("rst_grp_valid", 32'(bus.grp_valid), 32'd0);
    check("rst_grp_last",  32'(bus.grp_last),  32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic f, v; logic [2:0] vl; logic [AW-1:0] a; logic idle;
    logic rdy, emp, en, gv, gl; logic [2:0] e_vl; logic [AW-1:0] e_a;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic v, input logic [2:0] vl, input logic [AW-1:0] a,
                              input logic rdy, input logic emp, input logic en,
                              input logic gv, input logic gl,
                              input logic [2:0] e_vl, input logic [AW-1:0] e_a);
    vec_t r;
    r.f = 1'b0; r.v = v; r.vl = vl; r.a = a; r.idle = 1'b1;
    r.rdy = rdy; r.emp = emp; r.en = en; r.gv = gv; r.gl = gl;
    r.e_vl = e_vl; r.e_a = e_a;
    return r;
  endfunction

  initial begin
    int gv_cnt;
    rst = 1'b0;
    idle_inputs();
    cyc = 0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // single push {vlmul 2, addr 3}, then back-to-back {1,4},{5,9}
    //            v  vl  a  rdy emp en gv gl  e_vl e_a
    tbl[0]  = mk(1, 2, 3,  1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,  1, 0, 1, 0, 0, 2, 3);
    tbl[2]  = mk(0, 0, 0,  1, 1, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,  1, 1, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,  1, 1, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,  1, 1, 0, 1, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 4,  1, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 5, 9,  1, 0, 1, 0, 0, 1, 4);
    tbl[9]  = mk(0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,  1, 0, 1, 1, 1, 5, 9);
    tbl[11] = mk(0, 0, 0,  1, 1, 0, 1, 1, 0, 0);
    tbl[12] = mk(0, 0, 0,  1, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      bus.flush    = tbl[i].f;
      bus.in_valid = tbl[i].v;
      bus.in_vlmul = tbl[i].vl;
      bus.in_addr  = tbl[i].a;
      bus.agu_idle = tbl[i].idle;
      #4;
      check("tbl_in_ready",  32'(bus.in_ready),  32'(tbl[i].rdy));
      check("tbl_empty",     32'(bus.empty),     32'(tbl[i].emp));
      check("tbl_agu_en",    32'(bus.agu_en),    32'(tbl[i].en));
      check("tbl_grp_valid", 32'(bus.grp_valid), 32'(tbl[i].gv));
      check("tbl_grp_last",  32'(bus.grp_last),  32'(tbl[i].gl));
      if (tbl[i].en) begin
        check("tbl_agu_addr",  32'(bus.agu_addr),  32'(tbl[i].e_a));
        check("tbl_agu_vlmul", 32'(bus.agu_vlmul), 32'(tbl[i].e_vl));
      end
      @(posedge clk); #1;
    end

    // ---- fill with vlmul 3 while agu_idle is held low, then release ----
    do_reset();
    step(0, 1, 3, 10, 0);
    step(0, 1, 3, 11, 0);
    step(0, 1, 3, 12, 0);
    step(0, 1, 3, 13, 0);
    step(0, 1, 3, 14, 1);
    check("full_in_ready_low", 32'(s_ready), 32'd0);
    check("idle_rise_issue",   32'(s_en),    32'd1);
    step(0, 1, 3, 14, 1);
    check("ready_after_pop",   32'(s_ready), 32'd1);
    for (int i = 0; i < 45; i++) step(0, 0, 0, 0, 1);

    // ---- flush with 3 queued and cnt = 5 in flight ----
    do_reset();
    step(0, 1, 3, 1, 1);
    step(0, 1, 0, 2, 1);
    step(0, 1, 0, 3, 1);
    step(0, 1, 0, 4, 1);
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 5, 1);
    check("flush_no_issue", 32'(s_en), 32'd0);
    gv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1);
      if (i == 0) check("flush_empty", 32'(s_empty), 32'd1);
      if (s_gv) gv_cnt++;
    end
    check("flush_gv_tail", 32'(gv_cnt), 32'd4);

    // ---- reset in the middle of a group ----
    step(0, 1, 3, 7, 1);
    step(0, 1, 2, 8, 1);
    step(0, 0, 0, 0, 1);
    do_reset();
    step(0, 0, 0, 0, 1);
    check("post_rst_gv", 32'(s_gv), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);

    // ---- randomized traffic ----
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7,
           3'($urandom_range(0, 7)),
           AW'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vreg_group_issue.md
# vreg_group_issue

Issue buffer that sits directly upstream of the vector register-group address generator. It queues decoded register-group requests (base register, `vlmul`) from the decoder, pulses `agu_en` exactly when the generator can accept a new group, and chains groups back-to-back. It also tracks the group length itself and flags which generator output cycles carry valid and last register addresses, for the register file.

## Interface
- `ADDR_WIDTH`, 5: register address width; 32 vector registers.
- `DEPTH`, 4: queue entries; power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous queue clear.
- `in_valid` in 1: decoder request valid.
- `in_ready` out 1: queue can accept.
- `in_vlmul` in 3: LMUL code of the request.
- `in_addr` in ADDR_WIDTH: register-group base address.
- `agu_en` out 1: issue strobe to the generator.
- `agu_vlmul` out 3: head-entry `vlmul`.
- `agu_addr` out ADDR_WIDTH: head-entry base address.
- `agu_idle` in 1: generator idle flag.
- `grp_valid` out 1: generator address output is valid this cycle.
- `grp_last` out 1: generator address output is the last register of its group.
- `empty` out 1: queue empty.

## Operation
- The queue is a FIFO of {`vlmul`, `addr`} pairs with write/read pointers that wrap modulo `DEPTH`, plus an occupancy count of `$clog2(DEPTH)+1` bits.
  - `in_ready` = (count < DEPTH) && !`flush`.
  - A push happens when `in_valid` && `in_ready`.
- Group length L:
  - `vlmul` 0, 1, 2, 3 gives L = 1, 2, 4, 8.
  - `vlmul` 4 to 7 (fractional) gives L = 1.
- `cnt` is a 4-bit counter holding the remaining generator output cycles of the in-flight group.
  - On issue, `cnt` loads L.
  - Otherwise it decrements each cycle, saturating at 0.
- Issue permission `issue_ok` = (`cnt` == 1) || (`cnt` == 0 && `agu_idle`).
- `agu_en` = !`empty` && `issue_ok` && !`flush`. A pop occurs exactly when `agu_en` = 1.
- `agu_vlmul` and `agu_addr` are driven combinationally from the head entry. They are don't-care when `empty`.
- `grp_valid` = (`cnt` != 0). `grp_last` = (`cnt` == 1).
- Push and pop in the same cycle leave the count unchanged. This is legal at any occupancy except full, where `in_ready` = 0.
- `flush` resets both pointers and the count to 0. It drops any same-cycle push. It does not touch `cnt`, so a group already in flight finishes.

## Timing
- Reset (`rst` low) clears pointers, count and `cnt` immediately. Outputs during and after reset:
  - `in_ready` = 1, `empty` = 1;
  - `agu_en` = 0, `grp_valid` = 0, `grp_last` = 0.
- Reset mid-group abandons the group. No `grp_*` flags are produced afterwards.
- Push-to-issue latency is 1 cycle minimum. An entry pushed at edge t can raise `agu_en` in cycle t+1. There is no same-cycle bypass.
- Issue at cycle t gives `cnt` = L at cycle t+1.
  - `grp_valid` is high in cycles t+1 to t+L.
  - `grp_last` is high in cycle t+L.
  - This matches the generator presenting base through base+L-1 in those cycles.
- The next issue can occur in cycle t+L, the last-address cycle, giving zero-bubble chaining. Otherwise it waits for `cnt` = 0 with `agu_idle` = 1.
- While `cnt` is 0 and `agu_idle` is 0 (generator still leaving BUSY), the block holds off issue.
- The base address is passed through unshifted. The generator applies the shift by `vlmul`.

## Structure
- Shared package `vrvv_pkg` holds:
  - the `vlmul` code constants;
  - a `grp_len(vlmul)` function returning the 4-bit L.
- One sub-module, `sync_fifo` (parameters WIDTH and DEPTH), provides storage, pointers and count, with push, pop, flush, full and empty. The issue and `cnt` logic stays in the top module.

## Test plan
- Reset: hold `rst` low mid-burst, release → `in_ready` = 1, `empty` = 1, `agu_en` = 0, `grp_valid` = 0 on the first cycle.
- Single push `addr` = 3, `vlmul` = 2 at edge 0 → `agu_en` in cycle 1 with `agu_addr` = 3; `grp_valid` in cycles 2 to 5; `grp_last` only in cycle 5.
- Back-to-back push {`vlmul` 1, `addr` 4} then {`vlmul` 5, `addr` 9} → issues in cycle 1 and cycle 3, no bubble; `grp_valid` continuous in cycles 2 to 4; `grp_last` in cycles 3 and 4.
- Fill all 4 entries with `vlmul` = 3 → `in_ready` = 0 after the 4th push (no issue yet); `in_ready` returns to 1 the cycle after the first pop; wrap-around order is preserved.
- `flush` while 3 entries are queued and a group is in flight with `cnt` = 5 → `empty` = 1 next cycle; `agu_en` = 0; `grp_valid` continues 4 more cycles.
- `cnt` = 0 with `agu_idle` held 0 and one entry queued → no `agu_en` until `agu_idle` rises, then `agu_en` in that same cycle.
